vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA raster timing: pixel-clock enable, pixel counters hc/vc, blank, and hsync/vsync.
//  Feeds the sprite renderers (hc, vc, blank) and drives the monitor sync pins.
//  Sync and blank are also supplied delayed by PIPE_DLY pixels, to align with synchronous sprite-ROM latency.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
//  H_VISIBLE  640  visible pixels per line
//  H_FP       16   horizontal front porch, in pixels
//  H_SYNC     96   hsync pulse width, in pixels
//  H_BP       48   horizontal back porch, in pixels
//  V_VISIBLE  480  visible lines per frame
//  V_FP       10   vertical front porch, in lines
//  V_SYNC     2    vsync pulse width, in lines
//  V_BP       33   vertical back porch, in lines
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low)
//  PIPE_DLY   2    pixel delay applied to the *_d outputs; legal range 1..4
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  pix_en       out  1   one-clk pulse per pixel; marks when hc/vc advance
//  hc           out  11  horizontal pixel count, 0..H_TOTAL-1
//  vc           out  11  vertical line count, 0..V_TOTAL-1
//  blank        out  1   1 outside the visible area; aligned with hc/vc
//  hsync        out  1   horizontal sync; aligned with hc/vc
//  vsync        out  1   vertical sync; aligned with hc/vc
//  frame_start  out  1   one-clk pulse when the counters move to (0,0)
//  blank_d      out  1   blank delayed by PIPE_DLY pixels
//  hsync_d      out  1   hsync delayed by PIPE_DLY pixels
//  vsync_d      out  1   vsync delayed by PIPE_DLY pixels
// BEHAVIOUR
//  - Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
//  - Reset (asynchronous, takes effect immediately, including mid-frame):
//    div=0, pix_en=0, hc=0, vc=0, blank=0, frame_start=0.
//    hsync, vsync, hsync_d, vsync_d are driven to the inactive level (~SYNC_POL).
//    blank_d=1, and the whole delay line is filled with blanked/inactive values.
//  - Divider: div counts 0..CLK_DIV-1 and wraps. pix_en is registered and is 1 on the clk after div==CLK_DIV-1.
//    If CLK_DIV=1, pix_en=1 every clk after reset.
//  - On each clk with pix_en=1:
//    - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
//    - vc wraps from V_TOTAL-1 to 0 on the same edge that hc wraps.
//  - blank, hsync and vsync are registered and decoded from the next counter values, so they change on the same edge as hc/vc:
//    - blank = (hc>=H_VISIBLE) | (vc>=V_VISIBLE)
//    - hsync active for H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751)
//    - vsync active for V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491)
//  - frame_start is 1 for exactly one clk: the clk on which (hc,vc) became (0,0) by wrapping.
//    It is not asserted on leaving reset.
//  - Delay line: a PIPE_DLY-deep shift register of {blank,hsync,vsync}, advanced only when pix_en=1.
//    *_d outputs equal the base outputs as they were PIPE_DLY pixels earlier.
//  - Between pix_en pulses, all outputs hold.
//  - Widths: 11-bit counters cover totals up to 2047. Comparisons are unsigned.
// TESTING
//  1) Reset: assert rst mid-line at hc=300.
//     -> hc=vc=0, pix_en=0, hsync=vsync=1, blank_d=1 immediately, with no clk edge needed.
//  2) Divider: CLK_DIV=4.
//     -> pix_en is high for 1 of every 4 clks; hc steps 0->1->2 at a 4-clk spacing.
//  3) Line: count pix_en from hc=0.
//     -> blank rises at hc=640; hsync low at hc=656..751; hc wraps 799->0 and vc increments.
//  4) Frame: run 800*525 pixels.
//     -> vsync low only for vc=490,491.
//     -> frame_start pulses exactly once, when (799,524)->(0,0), and lasts 1 clk.
//  5) Delay: PIPE_DLY=2.
//     -> blank_d rises exactly 2 pix_en pulses after blank (hc=642); hsync_d falls at hc=658.
//  6) Polarity: SYNC_POL=1, CLK_DIV=1.
//     -> hsync is high at hc=656..751 and low elsewhere; pix_en is high every clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock enable, hc/vc counters, blank and sync,
// plus copies of blank/sync delayed by PIPE_DLY pixels to match sprite-ROM latency.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIPE_DLY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        blank_d,
  output logic        hsync_d,
  output logic        vsync_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic        ACT      = SYNC_POL;
  localparam logic        IDLE     = ~SYNC_POL;

  logic [DIV_W-1:0] div;
  logic [10:0]      hc_nxt, vc_nxt;
  logic             wrap_frame;
  logic             blank_nxt, hsync_nxt, vsync_nxt;
  logic [2:0]       dly [PIPE_DLY];

  // NOTE: state registers use non-blocking assignments and an async reset term in the
  // sensitivity list, so reset clears them immediately without waiting for a clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= (div == DIV_MAX) ? '0 : div + 1'b1;
      pix_en <= (div == DIV_MAX);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hc_nxt     = hc + 11'd1;
    vc_nxt     = vc;
    wrap_frame = 1'b0;
    if (hc == H_MAX) begin
      hc_nxt = '0;
      if (vc == V_MAX) begin
        vc_nxt     = '0;
        wrap_frame = 1'b1;
      end else begin
        vc_nxt = vc + 11'd1;
      end
    end
    blank_nxt = (hc_nxt >= H_VIS) || (vc_nxt >= V_VIS);
    hsync_nxt = (hc_nxt >= HS_START && hc_nxt < HS_END) ? ACT : IDLE;
    vsync_nxt = (vc_nxt >= VS_START && vc_nxt < VS_END) ? ACT : IDLE;
  end

  // Decoded outputs are registered from the next counter values so they switch with hc/vc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      blank       <= 1'b0;
      hsync       <= IDLE;
      vsync       <= IDLE;
      frame_start <= 1'b0;
      for (int i = 0; i < PIPE_DLY; i++) dly[i] <= {1'b1, IDLE, IDLE};
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hc          <= hc_nxt;
        vc          <= vc_nxt;
        blank       <= blank_nxt;
        hsync       <= hsync_nxt;
        vsync       <= vsync_nxt;
        frame_start <= wrap_frame;
        dly[0]      <= {blank, hsync, vsync};
        for (int i = 1; i < PIPE_DLY; i++) dly[i] <= dly[i-1];
      end
    end
  end

  assign blank_d = dly[PIPE_DLY-1][2];
  assign hsync_d = dly[PIPE_DLY-1][1];
  assign vsync_d = dly[PIPE_DLY-1][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: an arithmetic raster model queues the expected
// outputs per clk, a negedge monitor compares; resets land at random points mid-frame.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_en;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        blank;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        blank_d;
    logic        hsync_d;
    logic        vsync_d;
  } obs_t;

  typedef struct {
    int d, hv, hf, hs, hb, vv, vf, vs, vb, pd;
    bit pol;
  } cfg_t;

  // Small raster with a slow divider (whole frames fit in the run), and the full
  // 640x480 raster at one pixel per clk with active-high sync.
  localparam cfg_t CFG_A = '{d: 4, hv: 16, hf: 2, hs: 3, hb: 4, vv: 10, vf: 1, vs: 2, vb: 3,
                             pd: 3, pol: 1'b0};
  localparam cfg_t CFG_B = '{d: 1, hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2,
                             vb: 33, pd: 2, pol: 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        pix_en_a, blank_a, hsync_a, vsync_a, fs_a, blank_d_a, hsync_d_a, vsync_d_a;
  logic [10:0] hc_a, vc_a;
  logic        pix_en_b, blank_b, hsync_b, vsync_b, fs_b, blank_d_b, hsync_d_b, vsync_d_b;
  logic [10:0] hc_b, vc_b;

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_VISIBLE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .PIPE_DLY(3)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en_a), .hc(hc_a), .vc(vc_a),
    .blank(blank_a), .hsync(hsync_a), .vsync(vsync_a), .frame_start(fs_a),
    .blank_d(blank_d_a), .hsync_d(hsync_d_a), .vsync_d(vsync_d_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .SYNC_POL(1'b1), .PIPE_DLY(2)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en_b), .hc(hc_b), .vc(vc_b),
    .blank(blank_b), .hsync(hsync_b), .vsync(vsync_b), .frame_start(fs_b),
    .blank_d(blank_d_b), .hsync_d(hsync_d_b), .vsync_d(vsync_d_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = '{pix_en_a, hc_a, vc_a, blank_a, hsync_a, vsync_a, fs_a,
                   blank_d_a, hsync_d_a, vsync_d_a};
  assign obs_b = '{pix_en_b, hc_b, vc_b, blank_b, hsync_b, vsync_b, fs_b,
                   blank_d_b, hsync_d_b, vsync_d_b};

  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  obs_t qa[$];
  obs_t qb[$];

  // {blank, hsync, vsync} after n pixel steps; n==0 is the reset state.
  function automatic logic [2:0] raster(int n, cfg_t c);
    int  ht, vt, h, v;
    logic b, hs, vs;
    if (n == 0) return {1'b0, ~c.pol, ~c.pol};
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    b  = (h >= c.hv) || (v >= c.vv);
    hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
    vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
    return {b, hs, vs};
  endfunction

  // Expected outputs after the k-th clk edge since reset release (k==0: in reset).
  function automatic obs_t model(int kk, cfg_t c);
    obs_t o;
    int   ht, vt, n, n_prev;
    logic [2:0] cur, del;
    ht     = c.hv + c.hf + c.hs + c.hb;
    vt     = c.vv + c.vf + c.vs + c.vb;
    n      = (kk >= 1) ? (kk - 1) / c.d : 0;
    n_prev = (kk >= 2) ? (kk - 2) / c.d : 0;
    cur    = raster(n, c);
    del    = (n < c.pd) ? {1'b1, ~c.pol, ~c.pol} : raster(n - c.pd, c);
    o.pix_en      = (kk >= 1) && (kk % c.d == 0);
    o.hc          = 11'(n % ht);
    o.vc          = 11'((n / ht) % vt);
    o.blank       = cur[2];
    o.hsync       = cur[1];
    o.vsync       = cur[0];
    o.frame_start = (n != n_prev) && (n % (ht * vt) == 0);
    o.blank_d     = del[2];
    o.hsync_d     = del[1];
    o.vsync_d     = del[0];
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got pe=%b hc=%0d vc=%0d bhv=%b%b%b fs=%b bhv_d=%b%b%b want pe=%b hc=%0d vc=%0d bhv=%b%b%b fs=%b bhv_d=%b%b%b",
               name, k, act.pix_en, act.hc, act.vc, act.blank, act.hsync, act.vsync,
               act.frame_start, act.blank_d, act.hsync_d, act.vsync_d,
               exp.pix_en, exp.hc, exp.vc, exp.blank, exp.hsync, exp.vsync,
               exp.frame_start, exp.blank_d, exp.hsync_d, exp.vsync_d);
    end
  endtask

  // Stimulus side: each clk edge out of reset queues what both DUTs must show next.
  always @(posedge clk) begin
    if (!rst) begin
      k++;
      qa.push_back(model(k, CFG_A));
      qb.push_back(model(k, CFG_B));
    end
  end

  // Monitor side: sample away from the active edge and compare against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (qa.size() > 0) check("dut_a", obs_a, qa.pop_front());
      if (qb.size() > 0) check("dut_b", obs_b, qb.pop_front());
    end
  end

  // Asserted 2 time units after an edge, so the reset values must appear with no clk.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async_a", obs_a, model(0, CFG_A));
    check("rst_async_b", obs_b, model(0, CFG_B));
    qa.delete();
    qb.delete();
    k = 0;
    repeat (3) @(negedge clk);
    check("rst_hold_a", obs_a, model(0, CFG_A));
    check("rst_hold_b", obs_b, model(0, CFG_B));
    #1 rst = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #2;
    do_reset();
    run(301);          // dut_b is at hc=300 when reset hits mid-line
    do_reset();
    run(3500);         // two full frames of dut_a, four lines of dut_b
    do_reset();
    repeat (4) begin
      run($urandom_range(40, 1200));
      do_reset();
    end
    run(200);
    @(negedge clk);
    #1;
    checks++;
    if (qa.size() + qb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", qa.size() + qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
